cobs_decoder_axis: RTL
======================

// Module: cobs_decoder_axis
// PURPOSE
//  Consistent Overhead Byte Stuffing (COBS) decoder from an 8-bit AXIS byte stream to decoded frames.
//  - Input: 0x00-delimited COBS stream, as produced by the XADC packetizer or received from the host link.
//  - Output: decoded payload bytes, with tlast on the final byte of each frame.
//  - Flags truncated and oversize frames. Sits between the byte link and packet consumers.
// PARAMETERS
//  MAX_FRAME_BYTES  256  max decoded bytes per frame; beyond this the frame is dropped with an error
//  STATS_WIDTH      16   width of the statistics counters (used only with COBS_DECODER_STATS_EN)
// PORTS
//  clk              in   1   single clock for all logic
//  reset            in   1   synchronous, active-high
//  s_axis_tdata     in   8   encoded byte
//  s_axis_tvalid    in   1   encoded byte valid
//  s_axis_tready    out  1   decoder accepts encoded byte
//  m_axis_tdata     out  8   decoded byte
//  m_axis_tvalid    out  1   decoded byte valid
//  m_axis_tready    in   1   downstream accepts decoded byte
//  m_axis_tlast     out  1   last decoded byte of frame
//  m_axis_tuser     out  1   frame error; meaningful only on the tlast beat
//  frame_error_out  out  1   one-cycle pulse per errored frame
// BEHAVIOUR
//  Reset:
//  - All outputs 0; FSM in WAIT_CODE; pending_zero=0; hold register empty; group count and frame length 0.
//  - Reset mid-frame abandons the frame. No tlast is emitted for it.
//  Handshakes:
//  - Input beat when s_axis_tvalid & s_axis_tready. Output beat when m_axis_tvalid & m_axis_tready.
//  - s_axis_tready = !m_axis_tvalid | m_axis_tready, registered-output pipe.
//  - m_* hold stable while tvalid & !tready.
//  Decode datapath:
//  - Each accepted input byte yields at most one decoded byte, which goes into a 1-deep hold register.
//  - The previous held byte moves to m_* with tlast=0 at the same time.
//  - Hold delay is 1 input beat. This lets tlast ride on the true last byte without lookahead.
//  FSM:
//  - WAIT_CODE, byte C!=0: load group count = C-1.
//    - If pending_zero=1, decoded byte 0x00 is produced.
//    - Then pending_zero is set to (C!=0xFF).
//    - Go to DATA if C>1, otherwise stay in WAIT_CODE.
//  - WAIT_CODE, byte 0x00 (delimiter): the held byte, if any, goes out with tlast=1, tuser=0.
//    - pending_zero is cleared; the trailing implicit zero is never emitted.
//    - Empty frame (no bytes held): no output beat and no error.
//  - DATA, byte D!=0: produce D and decrement the count. When the count reaches 0, go to WAIT_CODE.
//  - DATA, byte 0x00: truncated frame. The held byte goes out with tlast=1, tuser=1.
//    - frame_error_out pulses. Go to WAIT_CODE with pending_zero=0.
//    - If nothing is held, there is no output beat, but frame_error_out still pulses.
//  - Oversize: producing byte MAX_FRAME_BYTES+1 is an error.
//    - The held byte goes out with tlast=1, tuser=1, and frame_error_out pulses.
//    - Go to DISCARD.
//  - DISCARD: consume input bytes until 0x00, then go to WAIT_CODE. No output in this state.
//  Arithmetic:
//  - Frame length counter is $clog2(MAX_FRAME_BYTES+2) bits, cleared at each delimiter.
//  - Group counter is 8 bits. 0xFF codes insert no zero.
// CONFIGURATION
//  COBS_DECODER_STATS_EN defined:
//  - Adds outputs frames_ok_out[STATS_WIDTH] and frames_err_out[STATS_WIDTH].
//  - Counters are reset to 0 by reset and saturate at all-ones.
//  - frames_ok_out increments on a tlast beat with tuser=0.
//  - frames_err_out increments on every frame_error_out pulse.
//  COBS_DECODER_STATS_EN undefined: the ports and counters do not exist. Decode behaviour is identical.
// TESTING
//  1. Basic frame: in 01 02 0F 02 07 00 -> out 00 0F 00 07; tlast on 07; tuser=0.
//  2. Backpressure: case 1 with m_axis_tready toggling 1-0 per cycle and s_axis_tvalid gapped.
//     -> identical byte sequence, no drops or duplicates.
//  3. Max group: in FF, 254x11, 02, 22, 00 -> out 254x11 then 22, with no 00 between; tlast on 22.
//  4. Truncation: in 04 AA BB 00 -> out AA, BB; tlast=1 and tuser=1 on BB.
//     - frame_error_out pulses once. The next frame 02 55 00 decodes to 55 with tuser=0.
//  5. Delimiter edge cases:
//     - Empty frames 00 00 -> no output and no error.
//     - MAX_FRAME_BYTES=4 with in 06 01 02 03 04 05 00 -> out 01 02 03 04 with tuser=1 on 04; 05 discarded.
//  6. Reset mid-frame: reset asserted 1 cycle after 03 AA -> all outputs 0.
//     - Then 02 33 00 -> out 33 with tlast; with STATS_EN, frames_ok_out=1 and frames_err_out=0.

Source files
------------

// File: rtl/cobs_decoder_axis.sv
// COBS byte-stream decoder, AXI-Stream in and out, one-beat hold for tlast.
// Optional frame statistics when COBS_DECODER_STATS_EN is defined.
module cobs_decoder_axis #(
  parameter int MAX_FRAME_BYTES = 256,
  parameter int STATS_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_error_out
`ifdef COBS_DECODER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] frames_ok_out,
  output logic [STATS_WIDTH-1:0] frames_err_out
`endif
);

  localparam int LW = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [LW-1:0] MAXL = LW'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    WAIT_CODE,
    DATA,
    DISCARD
  } st_t;

  st_t           st_q;
  logic [7:0]    cnt_q;
  logic          pz_q;
  logic [7:0]    hold_q;
  logic          hold_vld_q;
  logic [LW-1:0] len_q;
  logic [7:0]    m_data_q;
  logic          m_valid_q;
  logic          m_last_q;
  logic          m_user_q;
  logic          err_q;

  logic       acc;
  logic       is_zero;
  logic       prod;
  logic [7:0] pbyte;
  logic       term;
  logic       term_err;
  logic       ovf;
  logic       flush;
  logic       ferr;

  assign s_axis_tready   = !m_valid_q | m_axis_tready;
  assign acc             = s_axis_tvalid & s_axis_tready;
  assign is_zero         = (s_axis_tdata == 8'h00);
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tuser    = m_user_q;
  assign frame_error_out = err_q;

  always_comb begin
    prod     = 1'b0;
    pbyte    = 8'h00;
    term     = 1'b0;
    term_err = 1'b0;
    if (acc) begin
      unique case (st_q)
        WAIT_CODE: begin
          if (is_zero) term = 1'b1;
          else if (pz_q) prod = 1'b1;
        end
        DATA: begin
          if (is_zero) begin
            term     = 1'b1;
            term_err = 1'b1;
          end else begin
            prod  = 1'b1;
            pbyte = s_axis_tdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign ovf   = prod & (len_q == MAXL);
  assign flush = term | ovf;
  assign ferr  = term_err | ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= WAIT_CODE;
      cnt_q      <= 8'h00;
      pz_q       <= 1'b0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      len_q      <= '0;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (m_valid_q && m_axis_tready) m_valid_q <= 1'b0;
      if (acc) begin
        if (flush) begin
          if (hold_vld_q) begin
            m_data_q  <= hold_q;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b1;
            m_user_q  <= ferr;
          end
          hold_vld_q <= 1'b0;
          err_q      <= ferr;
        end else if (prod) begin
          if (hold_vld_q) begin
            m_data_q  <= hold_q;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
          end
          hold_q     <= pbyte;
          hold_vld_q <= 1'b1;
          len_q      <= len_q + 1'b1;
        end
        if (is_zero) len_q <= '0;
        unique case (st_q)
          WAIT_CODE: begin
            if (is_zero) begin
              pz_q <= 1'b0;
            end else begin
              cnt_q <= s_axis_tdata - 8'd1;
              pz_q  <= (s_axis_tdata != 8'hFF);
              if (s_axis_tdata > 8'd1) st_q <= DATA;
            end
          end
          DATA: begin
            if (is_zero) begin
              st_q <= WAIT_CODE;
              pz_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) st_q <= WAIT_CODE;
            end
          end
          DISCARD: begin
            if (is_zero) begin
              st_q <= WAIT_CODE;
              pz_q <= 1'b0;
            end
          end
          default: st_q <= WAIT_CODE;
        endcase
        // oversize wins over the normal group transition
        if (ovf) begin
          st_q <= DISCARD;
          pz_q <= 1'b0;
        end
      end
    end
  end

`ifdef COBS_DECODER_STATS_EN
  logic [STATS_WIDTH-1:0] ok_q;
  logic [STATS_WIDTH-1:0] er_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q <= '0;
      er_q <= '0;
    end else begin
      if (m_valid_q && m_axis_tready && m_last_q && !m_user_q && (ok_q != '1))
        ok_q <= ok_q + 1'b1;
      if (err_q && (er_q != '1))
        er_q <= er_q + 1'b1;
    end
  end

  assign frames_ok_out  = ok_q;
  assign frames_err_out = er_q;
`else
  logic unused_stats;
  assign unused_stats = ^STATS_WIDTH;
`endif

endmodule
